// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI target endpoint, MSB first, DATA_WIDTH-bit words, any CPOL/CPHA mode.
// Latency: SPI inputs cross SYNC_STAGES flops plus edge detect; rx_valid pulses one clk after the final sample edge.
// Backpressure: one-entry tx buffer via tx_valid/tx_ready; the rx side cannot stall (rx_valid is a pulse).
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk, cs_n, mosi      SPI bus from the master (asynchronous to clk, oversampled)
//   miso                  serial data to the master
//   tx_data/valid/ready   word for the next outgoing slot (one-entry buffer)
//   rx_data/valid         last received word, rx_valid is a one-cycle pulse
//   busy                  synchronized cs_n is low (frame in progress)
//
// Build option SPI_SLAVE_MISO_OE_EN: adds miso_oe (follows busy) for an external
// tri-state pad; miso then carries the tx shift MSB in every state.
// clk must run at least 8x faster than sclk.

module spi_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic                  miso_oe,
`endif
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   cs_hist_q,   cs_hist_d;

    // Core state
    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   reload_q, reload_d;
    logic                   skip_q, skip_d;
    logic                   buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0]  buf_dat_q, buf_dat_d;

    // Registered outputs
    logic                   miso_q, miso_d;
    logic                   tx_ready_q, tx_ready_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic                   miso_oe_q, miso_oe_d;
`endif

    // Combinational helpers
    logic                   sclk_s, cs_s, mosi_s;
    logic                   lead_edge, trail_edge;
    logic                   sample_edge, change_edge;
    logic                   frame_start, frame_end;
    logic [DATA_WIDTH-1:0]  load_word;
    logic [DATA_WIDTH-1:0]  rx_next;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        cs_s   = cs_sync_q[SYNC_STAGES-1];
        mosi_s = mosi_sync_q[SYNC_STAGES-1];

        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;

        // Leading edge leaves the idle level, trailing edge returns to it.
        lead_edge   = (sclk_hist_q == CPOL) && (sclk_s != CPOL);
        trail_edge  = (sclk_hist_q != CPOL) && (sclk_s == CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        change_edge = CPHA ? lead_edge  : trail_edge;
        frame_start = cs_hist_q && !cs_s;
        frame_end   = !cs_hist_q && cs_s;

        // An empty buffer sends zeros rather than stale data.
        load_word = buf_full_q ? buf_dat_q : '0;
        rx_next   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        reload_d   = reload_q;
        skip_d     = skip_q;
        buf_full_d = buf_full_q;
        buf_dat_d  = buf_dat_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        // Buffer write only when empty; a load only empties a full buffer,
        // so the two never act on the buffer in the same cycle.
        if (tx_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_dat_d  = tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    tx_shift_d = load_word;
                    if (buf_full_q) begin
                        buf_full_d = 1'b0;
                    end
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    reload_d   = 1'b0;
                    // With CPHA=1 the MSB is already on miso, so the first
                    // leading edge of the frame must not shift it away.
                    skip_d     = CPHA;
                    state_d    = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (sample_edge) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // Sample and change edges come from opposite sclk transitions,
                // so they never fall in the same cycle.
                if (change_edge) begin
                    if (reload_q) begin
                        tx_shift_d = load_word;
                        if (buf_full_q) begin
                            buf_full_d = 1'b0;
                        end
                        reload_d = 1'b0;
                    end else if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
                // A partial word is simply abandoned; a word completing in
                // this same cycle was already delivered above.
                if (frame_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_ACTIVE);
        tx_ready_d = !buf_full_d;
`ifdef SPI_SLAVE_MISO_OE_EN
        miso_d    = tx_shift_d[DATA_WIDTH-1];
        miso_oe_d = busy_d;
`else
        miso_d    = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sclk_hist_q <= CPOL;
            cs_hist_q   <= 1'b1;
            state_q     <= ST_IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            reload_q    <= 1'b0;
            skip_q      <= 1'b0;
            buf_full_q  <= 1'b0;
            buf_dat_q   <= '0;
            miso_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe_q   <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            reload_q    <= reload_d;
            skip_q      <= skip_d;
            buf_full_q  <= buf_full_d;
            buf_dat_q   <= buf_dat_d;
            miso_q      <= miso_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe_q   <= miso_oe_d;
`endif
        end
    end

    assign miso     = miso_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
`ifdef SPI_SLAVE_MISO_OE_EN
    assign miso_oe  = miso_oe_q;
`endif

endmodule
